xform_fifo: RTL

XFORM_FIFO -- requirements
Module: xform_fifo

---
 rtl/xform_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/xform_fifo.sv
// Transforming FIFO: each write is inverted and/or bit-reversed according to mode as it is pushed.
// Registered-only handshakes, occupancy level, sticky overflow flag and an output transfer counter.
module xform_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 mode,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [15:0]                xfer_count
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [15:0]      r_xfer;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_xform;

  assign in_ready   = (r_level != LevelFull);
  assign out_valid  = (r_level != '0);
  assign out_data   = r_mem[r_rptr];
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign xfer_count = r_xfer;

  assign w_push = in_valid & in_ready & ~rst;
  assign w_pop  = out_valid & out_ready & ~rst;

  // mode[0] inverts first, mode[1] then bit-reverses the (possibly inverted) word.
  assign w_inv = mode[0] ? ~in_data : in_data;
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign w_rev[g] = w_inv[WIDTH-1-g];
  end
  assign w_xform = mode[1] ? w_rev : w_inv;

  // Storage is never cleared; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_xform;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_xfer     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
        r_xfer <= r_xfer + 16'd1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
